// File: rtl/prim_sync_filter.sv
// prim_sync_filter
//   Multi-channel input synchroniser for asynchronous pins or foreign-clock
//   levels. Each channel has a Stages-deep flop chain, an optional glitch
//   filter, and registered rising/falling edge pulses. Channels share no state.
//
//   Compile-time option: define PRIM_SYNC_FILTER_EN to include the glitch
//   filter. Without it, q_o follows the synchronised level every cycle, which
//   behaves like FiltCycles=1, and FiltCycles is ignored.
//
// Parameters
//   Width      number of independent channels (>=1)
//   Stages     synchroniser depth per channel (2..4)
//   FiltCycles consecutive stable cycles before q_o follows (>=1)
//   ResetValue reset value of every sync stage and of q_o
//
// Ports
//   clk_i   sole clock
//   rst_i   asynchronous, active-high reset
//   d_i     asynchronous input levels
//   q_o     synchronised (and filtered) levels
//   rise_o  one-cycle pulse in the first cycle q_o shows 0->1
//   fall_o  one-cycle pulse in the first cycle q_o shows 1->0

// Per-channel slice: sync chain, optional filter, edge detect.
module prim_sync_filter_lane #(
  parameter int   Stages     = 2,
  parameter int   FiltCycles = 4,
  parameter logic RstVal     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  if (Stages < 2 || Stages > 4) begin : g_bad_stages
    $error("prim_sync_filter: Stages must be 2..4");
  end
  if (FiltCycles < 1) begin : g_bad_filt
    $error("prim_sync_filter: FiltCycles must be >= 1");
  end

  logic [Stages-1:0] stage;
  logic              s;
  logic              q_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stage <= {Stages{RstVal}};
    else       stage <= {stage[Stages-2:0], d_i};
  end

  assign s = stage[Stages-1];

`ifdef PRIM_SYNC_FILTER_EN
  localparam int CntW = (FiltCycles > 1) ? $clog2(FiltCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FiltCycles - 1);

  logic [CntW-1:0] cnt, cnt_next;

  // cnt counts consecutive cycles in which s disagrees with q. Any cycle of
  // agreement clears it, so only a run of FiltCycles mismatches moves q.
  always_comb begin
    q_next   = q_o;
    cnt_next = '0;
    if (s != q_o) begin
      if (cnt == CntMax) q_next   = s;
      else               cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= cnt_next;
  end
`else
  assign q_next = s;
`endif

  // Pulses are registered together with q so each one lines up with the
  // first cycle q_o shows the new level. Reset forces q and the pulses, so
  // release never produces a pulse by itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o    <= RstVal;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      q_o    <= q_next;
      rise_o <= ~q_o &  q_next;
      fall_o <=  q_o & ~q_next;
    end
  end

endmodule

module prim_sync_filter #(
  parameter int               Width      = 4,
  parameter int               Stages     = 2,
  parameter int               FiltCycles = 4,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  if (Width < 1) begin : g_bad_width
    $error("prim_sync_filter: Width must be >= 1");
  end

  for (genvar c = 0; c < Width; c++) begin : g_lane
    prim_sync_filter_lane #(
      .Stages     (Stages),
      .FiltCycles (FiltCycles),
      .RstVal     (ResetValue[c])
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (d_i[c]),
      .q_o    (q_o[c]),
      .rise_o (rise_o[c]),
      .fall_o (fall_o[c])
    );
  end

endmodule

// File: tb/tb_prim_sync_filter.sv
// Self-checking bench for prim_sync_filter. A cycle model pushes the expected
// q/rise/fall onto a scoreboard queue at each edge; the entry is popped and
// compared 1 time unit later. Directed checks cover latency, glitch rejection,
// mid-count asynchronous reset and channel independence.
module tb_prim_sync_filter;

  localparam int W = 4;
`ifdef PRIM_SYNC_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int S    = 2;
`else
  localparam bit FILT = 1'b0;
  localparam int S    = 3;
`endif
  localparam int           F   = 4;
  localparam logic [W-1:0] RV  = 4'b0101;
  localparam int           LAT = FILT ? S + F : S + 1;
  localparam int           MID = FILT ? S + 2 : 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] d_i   = '0;
  logic [W-1:0] q_o, rise_o, fall_o;

  always #5 clk_i = ~clk_i;

  prim_sync_filter #(
    .Width      (W),
    .Stages     (S),
    .FiltCycles (F),
    .ResetValue (RV)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (d_i),
    .q_o    (q_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_stage [S];
  logic [W-1:0] m_q, m_rise, m_fall;
  int           m_cnt [W];
  logic [W-1:0] d_drv;
  logic         rst_drv;
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_stage[i] = RV;
    for (int c = 0; c < W; c++) m_cnt[c] = 0;
    m_q    = RV;
    m_rise = '0;
    m_fall = '0;
  endtask

  // Expected outputs after one clock edge that samples d with reset r.
  task automatic model_step(input logic [W-1:0] d, input logic r);
    logic [W-1:0] s, qn;
    exp_t         e;
    if (r) begin
      model_reset();
    end else begin
      s  = m_stage[S-1];
      qn = m_q;
      for (int c = 0; c < W; c++) begin
        if (!FILT) qn[c] = s[c];
        else if (s[c] == m_q[c]) m_cnt[c] = 0;
        else if (m_cnt[c] == F - 1) begin
          qn[c]    = s[c];
          m_cnt[c] = 0;
        end else m_cnt[c]++;
      end
      m_rise = ~m_q & qn;
      m_fall = m_q & ~qn;
      m_q    = qn;
      for (int i = S - 1; i > 0; i--) m_stage[i] = m_stage[i-1];
      m_stage[0] = d;
    end
    e.q    = m_q;
    e.rise = m_rise;
    e.fall = m_fall;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    d_i   = d_drv;
    rst_i = rst_drv;
    @(posedge clk_i);
    model_step(d_drv, rst_drv);
    #1;
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("q", q_o, e.q);
      check("rise", rise_o, e.rise);
      check("fall", fall_o, e.fall);
      check("excl", rise_o & fall_o, 0);
    end
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  // Edges until (q_o & mask) == val, counting the edge that first samples the
  // current d_drv; -1 if the bound expires.
  task automatic wait_q(input logic [W-1:0] mask, input logic [W-1:0] val, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if ((q_o & mask) == (val & mask)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic glitch(input int ch, input int len, output int hi, output int nr, output int nf);
    hi = 0; nr = 0; nf = 0;
    d_drv[ch] = 1'b1;
    for (int i = 0; i < len + 16; i++) begin
      if (i == len) d_drv[ch] = 1'b0;
      cycle();
      hi += int'(q_o[ch]);
      nr += int'(rise_o[ch]);
      nf += int'(fall_o[ch]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, nr, nf;
    model_reset();

    // Reset and release with inputs opposite to the reset value.
    d_drv   = 4'b1010;
    rst_drv = 1'b1;
    run(3);
    check("rst_q", q_o, RV);
    rst_drv = 1'b0;
    wait_q(4'hF, 4'b1010, n);
    check("rel_lat", n, LAT);
    check("rel_rise", rise_o, 4'b1010);
    check("rel_fall", fall_o, 4'b0101);
    cycle();
    check("rel_pulse_end", rise_o | fall_o, 0);

    // Single-channel step latency.
    d_drv = 4'b1011;
    wait_q(4'b0001, 4'b0001, n);
    check("lat0", n, LAT);
    check("rise0", rise_o[0], 1);
    cycle();
    check("rise0_end", rise_o[0], 0);

    // Glitches on channel 1 (settled low first).
    d_drv = 4'b1001;
    run(LAT + 2);
    glitch(1, 3, hi, nr, nf);
    check("g3_hi", hi, FILT ? 0 : 3);
    check("g3_rise", nr, FILT ? 0 : 1);
    check("g3_fall", nf, FILT ? 0 : 1);
    glitch(1, 4, hi, nr, nf);
    check("g4_hi", hi, 4);
    check("g4_rise", nr, 1);
    check("g4_fall", nf, 1);
    glitch(1, 1, hi, nr, nf);
    check("g1_hi", hi, FILT ? 0 : 1);
    check("g1_rise", nr, FILT ? 0 : 1);
    check("g1_fall", nf, FILT ? 0 : 1);

    // Asynchronous reset while channel 3 is part way to rising.
    d_drv = 4'b0010;
    run(LAT + 2);
    d_drv = 4'b1010;
    run(MID);
    rst_i = 1'b1;
    #1;
    check("arst_q", q_o, RV);
    check("arst_pulse", rise_o | fall_o, 0);
    model_reset();
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    wait_q(4'b1000, 4'b1000, n);
    check("arst_lat", n, LAT);

    // Simultaneous mixed-direction transitions.
    d_drv = 4'b0101;
    wait_q(4'hF, 4'b0101, n);
    check("ind1_lat", n, LAT);
    check("ind1_rise", rise_o, 4'b0101);
    check("ind1_fall", fall_o, 4'b1010);
    d_drv = 4'b0011;
    wait_q(4'b0110, 4'b0010, n);
    check("ind2_lat", n, LAT);
    check("ind2_rise", rise_o, 4'b0010);
    check("ind2_fall", fall_o, 4'b0100);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
